// File: rtl/timer_pkg.sv
// Shared types and constants for the tick countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} timer_state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t mt;
    bcd_t mo;
    bcd_t st;
    bcd_t so;
  } mmss_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

  // Clamp each preset digit to the largest value its position may hold.
  function automatic mmss_t sat_preset(input mmss_t p, input bcd_t mt_max);
    mmss_t r;
    r.mt = (p.mt > mt_max)       ? mt_max       : p.mt;
    r.mo = (p.mo > DIGIT_MAX)    ? DIGIT_MAX    : p.mo;
    r.st = (p.st > SEC_TENS_MAX) ? SEC_TENS_MAX : p.st;
    r.so = (p.so > DIGIT_MAX)    ? DIGIT_MAX    : p.so;
    return r;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; borrows out and wraps to MAX when decremented from 0.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  bcd_t ld_val,
  input  logic dec,
  output bcd_t digit,
  output logic borrow
);

  bcd_t digit_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '0;
    end else if (load) begin
      digit_q <= ld_val;
    end else if (dec) begin
      digit_q <= (digit_q == '0) ? MAX : digit_q - 4'd1;
    end
  end

  assign digit  = digit_q;
  assign borrow = dec && (digit_q == '0);

endmodule

// File: rtl/tick_countdown_timer.sv
// MM:SS countdown driven by a slow tick strobe, four chained BCD digits.
// Optional warn blink in the final seconds is enabled by defining TIMER_WARN_BLINK_EN.
module tick_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned WARN_SEC     = 10,
  parameter int unsigned MIN_TENS_MAX = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic        start,
  input  logic        pause,
  input  logic [15:0] preset_bcd,
  output logic [15:0] time_bcd,
  output logic        running,
  output logic        expired,
  output logic        warn
);

  localparam bcd_t MtMax = bcd_t'(MIN_TENS_MAX);

  timer_state_t state_q;
  logic         tick_q, running_q, expired_q;
  logic         tick_rise, do_dec, at_one, is_zero;
  logic         b_so, b_st, b_mo, b_mt;
  mmss_t        ld_val, cur;

  assign tick_rise = tick & ~tick_q;
  assign do_dec    = (state_q == RUN) && !load && !pause && tick_rise;
  assign ld_val    = sat_preset(mmss_t'(preset_bcd), MtMax);
  assign at_one    = (cur == mmss_t'(16'h0001));
  assign is_zero   = (cur == mmss_t'(16'h0000));

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_so (
    .clk(clk), .reset(reset), .load(load), .ld_val(ld_val.so), .dec(do_dec),
    .digit(cur.so), .borrow(b_so)
  );
  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_st (
    .clk(clk), .reset(reset), .load(load), .ld_val(ld_val.st), .dec(b_so),
    .digit(cur.st), .borrow(b_st)
  );
  bcd_down_digit #(.MAX(DIGIT_MAX)) u_mo (
    .clk(clk), .reset(reset), .load(load), .ld_val(ld_val.mo), .dec(b_st),
    .digit(cur.mo), .borrow(b_mo)
  );
  bcd_down_digit #(.MAX(MtMax)) u_mt (
    .clk(clk), .reset(reset), .load(load), .ld_val(ld_val.mt), .dec(b_mo),
    .digit(cur.mt), .borrow(b_mt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      tick_q    <= tick;
      expired_q <= 1'b0;
      if (load) begin
        state_q   <= IDLE;
        running_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!pause && start && !is_zero) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end else if (tick_rise && at_one) begin
              state_q   <= EXPIRED;
              running_q <= 1'b0;
              expired_q <= 1'b1;
            end
          end
          PAUSE: begin
            if (!pause && start) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          EXPIRED: ;
          default: ;
        endcase
      end
    end
  end

`ifdef TIMER_WARN_BLINK_EN
  // Toggle when the post-decrement value is at or under the threshold, i.e. cur <= WARN_SEC+1.
  localparam logic [15:0] WarnThr = {8'h00, 4'(WARN_SEC / 10), 4'(WARN_SEC % 10)};
  localparam logic [15:0] WarnP1  = {8'h00, 4'((WARN_SEC + 1) / 10), 4'((WARN_SEC + 1) % 10)};

  logic warn_q;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      warn_q <= 1'b0;
    end else if (state_q == RUN && !pause) begin
      if (tick_rise) begin
        if (at_one)                     warn_q <= 1'b0;
        else if (cur <= mmss_t'(WarnP1)) warn_q <= ~warn_q;
        else                            warn_q <= 1'b0;
      end else if (cur > mmss_t'(WarnThr)) begin
        warn_q <= 1'b0;
      end
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

  assign time_bcd = cur;
  assign running  = running_q;
  assign expired  = expired_q;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Directed self-checking bench for tick_countdown_timer.
module tb_tick_countdown_timer;

  logic        clk = 1'b0;
  logic        reset, tick, load, start, pause;
  logic [15:0] preset_bcd;
  logic [15:0] time_bcd;
  logic        running, expired, warn;

  int checks = 0;
  int errors = 0;

`ifdef TIMER_WARN_BLINK_EN
  localparam bit BlinkEn = 1'b1;
`else
  localparam bit BlinkEn = 1'b0;
`endif

  tick_countdown_timer #(.WARN_SEC(10), .MIN_TENS_MAX(9)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .start(start), .pause(pause),
    .preset_bcd(preset_bcd), .time_bcd(time_bcd), .running(running), .expired(expired),
    .warn(warn)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    preset_bcd = v; load = 1'b1; step(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; step(); tick = 1'b0; step();
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 0; load = 0; start = 0; pause = 0; preset_bcd = '0;
    step(); step();
    reset = 1'b0;
    checks++;
    if ({time_bcd, running, expired, warn} !== {16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL reset: got t=%h r=%b e=%b w=%b want 0000 0 0 0",
               time_bcd, running, expired, warn);
    end
  endtask

  task automatic test_expiry();
    do_load(16'h0003);
    do_start();
    checks++;
    if ({time_bcd, running} !== {16'h0003, 1'b1}) begin
      errors++; $display("FAIL exp_start: got %h r=%b want 0003 r=1", time_bcd, running);
    end
    do_tick();
    do_tick();
    checks++;
    if (time_bcd !== 16'h0001) begin
      errors++; $display("FAIL exp_cnt: got %h want 0001", time_bcd);
    end
    tick = 1'b1; step();
    checks++;
    if ({time_bcd, running, expired} !== {16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL exp_hit: got %h r=%b e=%b want 0000 r=0 e=1", time_bcd, running, expired);
    end
    tick = 1'b0; step();
    checks++;
    if ({time_bcd, expired} !== {16'h0000, 1'b0}) begin
      errors++; $display("FAIL exp_pulse: got %h e=%b want 0000 e=0", time_bcd, expired);
    end
  endtask

  task automatic test_borrow();
    do_load(16'h1000); do_start(); do_tick();
    checks++;
    if (time_bcd !== 16'h0959) begin
      errors++; $display("FAIL borrow_min: got %h want 0959", time_bcd);
    end
    do_load(16'h0100);
    checks++;
    if ({time_bcd, running} !== {16'h0100, 1'b0}) begin
      errors++; $display("FAIL reload: got %h r=%b want 0100 r=0", time_bcd, running);
    end
    do_start(); do_tick();
    checks++;
    if (time_bcd !== 16'h0059) begin
      errors++; $display("FAIL borrow_tens: got %h want 0059", time_bcd);
    end
  endtask

  task automatic test_pause();
    do_load(16'h0005); do_start(); do_tick(); do_tick();
    // pause and tick in the same cycle: pause wins
    pause = 1'b1; tick = 1'b1; step(); pause = 1'b0; tick = 1'b0; step();
    checks++;
    if ({time_bcd, running} !== {16'h0003, 1'b0}) begin
      errors++; $display("FAIL pause_enter: got %h r=%b want 0003 r=0", time_bcd, running);
    end
    for (int i = 0; i < 3; i++) do_tick();
    pause = 1'b1; start = 1'b1; step(); pause = 1'b0; start = 1'b0;
    checks++;
    if ({time_bcd, running} !== {16'h0003, 1'b0}) begin
      errors++; $display("FAIL pause_hold: got %h r=%b want 0003 r=0", time_bcd, running);
    end
    do_start(); do_tick();
    checks++;
    if ({time_bcd, running} !== {16'h0002, 1'b1}) begin
      errors++; $display("FAIL resume: got %h r=%b want 0002 r=1", time_bcd, running);
    end
  endtask

  task automatic test_saturate_level();
    do_load(16'hFF7C);
    checks++;
    if (time_bcd !== 16'h9959) begin
      errors++; $display("FAIL saturate: got %h want 9959", time_bcd);
    end
    do_start();
    tick = 1'b1;
    for (int i = 0; i < 5; i++) step();
    tick = 1'b0; step();
    checks++;
    if (time_bcd !== 16'h9958) begin
      errors++; $display("FAIL tick_level: got %h want 9958", time_bcd);
    end
  endtask

  task automatic test_idle_expired();
    do_load(16'h0000); do_start();
    checks++;
    if ({time_bcd, running} !== {16'h0000, 1'b0}) begin
      errors++; $display("FAIL start_zero: got %h r=%b want 0000 r=0", time_bcd, running);
    end
    do_load(16'h0001); do_start(); do_tick();
    do_start(); do_tick();
    pause = 1'b1; step(); pause = 1'b0;
    checks++;
    if ({time_bcd, running, expired} !== {16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL expired_hold: got %h r=%b e=%b want 0000 r=0 e=0", time_bcd, running, expired);
    end
    do_load(16'h0030);
    checks++;
    if ({time_bcd, running} !== {16'h0030, 1'b0}) begin
      errors++; $display("FAIL exp_reload: got %h r=%b want 0030 r=0", time_bcd, running);
    end
    do_start();
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("FAIL exp_restart: got r=%b want r=1", running);
    end
  endtask

  task automatic test_warn_reset();
    logic [15:0] exp_t [4] = '{16'h0011, 16'h0010, 16'h0009, 16'h0008};
    logic        exp_w [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_load(16'h0012); do_start();
    for (int i = 0; i < 4; i++) begin
      do_tick();
      checks++;
      if ({time_bcd, warn} !== {exp_t[i], exp_w[i] & BlinkEn}) begin
        errors++;
        $display("FAIL warn_%0d: got %h w=%b want %h w=%b", i, time_bcd, warn, exp_t[i],
                 exp_w[i] & BlinkEn);
      end
    end
    reset = 1'b1; step(); reset = 1'b0;
    checks++;
    if ({time_bcd, running, expired, warn} !== {16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL mid_reset: got t=%h r=%b e=%b w=%b want 0000 0 0 0",
               time_bcd, running, expired, warn);
    end
    do_start();
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got r=%b want r=0", running);
    end
  endtask

  initial begin
    test_reset();
    test_expiry();
    test_borrow();
    test_pause();
    test_saturate_level();
    test_idle_expired();
    test_warn_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
